// File: rtl/spindle_index_gen.sv
// Disk rotation emulator: produces the active-low /INDEX pulse once per revolution
// at 300/360 rpm, a spin-ready flag after a settling period, and a revolution counter.
module spindle_index_gen #(
  parameter int CLK_HZ      = 12000000,
  parameter int INDEX_W     = 24000,
  parameter int SPINUP_REVS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin_en,
  input  logic       spin_ss,
  input  logic       disk_in,
  output logic       index_n,
  output logic       spin_ready,
  output logic [7:0] rev_cnt
);

  localparam int P300 = CLK_HZ / 5;
  localparam int P360 = CLK_HZ / 6;
  localparam int PH_W = $clog2(P300);
  localparam int RV_W = $clog2(SPINUP_REVS + 1);

  localparam logic [PH_W-1:0] P300_LAST = PH_W'(P300 - 1);
  localparam logic [PH_W-1:0] P360_LAST = PH_W'(P360 - 1);
  localparam logic [PH_W-1:0] IDX_W_C   = PH_W'(INDEX_W);
  localparam logic [RV_W-1:0] REVS_C    = RV_W'(SPINUP_REVS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPINUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t          state_r;
  logic [PH_W-1:0] phase_r;
  logic [RV_W-1:0] revs_r;
  logic            ss_r;

  logic            change_s;
  logic [PH_W-1:0] p_last_s;
  logic            wrap_s;

  // A speed change takes effect on the very edge it is seen, so the wrap test uses the new period.
  always_comb begin
    change_s = (spin_ss != ss_r);
    p_last_s = spin_ss ? P360_LAST : P300_LAST;
    wrap_s   = (phase_r >= p_last_s);
  end

  // Rotation state machine with registered index, ready and revolution count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      phase_r    <= '0;
      revs_r     <= '0;
      ss_r       <= 1'b0;
      index_n    <= 1'b1;
      spin_ready <= 1'b0;
      rev_cnt    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          phase_r    <= '0;
          index_n    <= 1'b1;
          spin_ready <= 1'b0;
          if (spin_en) begin
            state_r <= SPINUP;
            revs_r  <= '0;
            ss_r    <= spin_ss;
          end else begin
            state_r <= IDLE;
          end
        end
        SPINUP, RUN: begin
          if (!spin_en) begin
            // Stopping wins over wrap and speed change; rev_cnt is kept.
            state_r    <= IDLE;
            phase_r    <= '0;
            revs_r     <= '0;
            spin_ready <= 1'b0;
            index_n    <= 1'b1;
          end else begin
            index_n <= ~(disk_in && (phase_r < IDX_W_C));
            if (wrap_s) begin
              phase_r <= '0;
              rev_cnt <= rev_cnt + 8'd1;
            end else begin
              phase_r <= phase_r + PH_W'(1);
            end
            if (change_s) begin
              ss_r       <= spin_ss;
              revs_r     <= '0;
              state_r    <= SPINUP;
              spin_ready <= 1'b0;
            end else if (state_r == SPINUP && wrap_s) begin
              revs_r <= revs_r + RV_W'(1);
              if (revs_r + RV_W'(1) == REVS_C) begin
                state_r    <= RUN;
                spin_ready <= 1'b1;
              end else begin
                state_r <= SPINUP;
              end
            end else begin
              state_r <= state_r;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          phase_r    <= '0;
          revs_r     <= '0;
          index_n    <= 1'b1;
          spin_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spindle_index_gen.sv
// Directed bench for spindle_index_gen with a scaled clock (P300=120, P360=100 cycles).
module tb_spindle_index_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       spin_en;
  logic       spin_ss;
  logic       disk_in;
  logic       index_n;
  logic       spin_ready;
  logic [7:0] rev_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lows   = 0;

  spindle_index_gen #(
    .CLK_HZ(600),
    .INDEX_W(4),
    .SPINUP_REVS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spin_en(spin_en),
    .spin_ss(spin_ss),
    .disk_in(disk_in),
    .index_n(index_n),
    .spin_ready(spin_ready),
    .rev_cnt(rev_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int k);
    while (cyc < k) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; spin_en = 1'b0; spin_ss = 1'b0; disk_in = 1'b1;
    tick(); tick();
    chk("rst_index_n", index_n, 1);
    chk("rst_ready", spin_ready, 0);
    chk("rst_rev", rev_cnt, 0);
    rst = 1'b0;
    tick();

    // Spin-up at 300 rpm; N is the cycle in which spin_en is first sampled.
    spin_en = 1'b1; spin_ss = 1'b0; cyc = 0;
    go(1);     chk("s300_n1_idx", index_n, 1);
    go(2);     chk("s300_n2_idx", index_n, 0);
    go(5);     chk("s300_n5_idx", index_n, 0);
    go(6);     chk("s300_n6_idx", index_n, 1);
    go(121);   chk("s300_n121_idx", index_n, 1);
               chk("s300_n121_rev", rev_cnt, 1);
    go(122);   chk("s300_n122_idx", index_n, 0);
    go(240);   chk("s300_n240_rdy", spin_ready, 0);
    go(241);   chk("s300_n241_rdy", spin_ready, 1);
               chk("s300_n241_rev", rev_cnt, 2);

    // Speed change 0->1 while phase = 110 in RUN.
    go(351);   spin_ss = 1'b1;
    go(352);   chk("chg_rdy_drop", spin_ready, 0);
               chk("chg_wrap_rev", rev_cnt, 3);
    go(353);   chk("chg_idx_low", index_n, 0);
    go(452);   chk("chg_n452_idx", index_n, 1);
               chk("chg_n452_rev", rev_cnt, 4);
    go(453);   chk("chg_n453_idx", index_n, 0);
    go(551);   chk("chg_n551_rdy", spin_ready, 0);
    go(552);   chk("chg_n552_rdy", spin_ready, 1);
               chk("chg_n552_rev", rev_cnt, 5);

    // Stop in the middle of an index pulse.
    go(553);   chk("stop_pre_idx", index_n, 0);
    spin_en = 1'b0;
    go(554);   chk("stop_idx", index_n, 1);
               chk("stop_rdy", spin_ready, 0);
               chk("stop_rev", rev_cnt, 5);
    go(560);   chk("stop_idle_idx", index_n, 1);
               chk("stop_idle_rev", rev_cnt, 5);

    // 360 rpm from idle.
    spin_en = 1'b1; spin_ss = 1'b1; cyc = 0;
    go(2);     chk("s360_n2_idx", index_n, 0);
    go(5);     chk("s360_n5_idx", index_n, 0);
    go(6);     chk("s360_n6_idx", index_n, 1);
    go(101);   chk("s360_n101_idx", index_n, 1);
    go(102);   chk("s360_n102_idx", index_n, 0);
    go(105);   chk("s360_n105_idx", index_n, 0);
    go(106);   chk("s360_n106_idx", index_n, 1);
    go(200);   chk("s360_n200_rdy", spin_ready, 0);
    go(201);   chk("s360_n201_rdy", spin_ready, 1);
               chk("s360_n201_rev", rev_cnt, 7);

    // No media: rotation runs, index stays high.
    spin_en = 1'b0;
    tick();
    spin_en = 1'b1; spin_ss = 1'b0; disk_in = 1'b0; cyc = 0; lows = 0;
    while (cyc < 240) begin
      tick();
      if (index_n !== 1'b1) lows++;
    end
    chk("nomedia_lows", lows, 0);
    chk("nomedia_n240_rdy", spin_ready, 0);
    go(241);   chk("nomedia_n241_rdy", spin_ready, 1);
               chk("nomedia_n241_rev", rev_cnt, 9);
    disk_in = 1'b1;

    // Counter wrap 255 -> 0, then reset in mid-pulse.
    go(29761); chk("wrap_255a", rev_cnt, 255);
    go(29880); chk("wrap_255b", rev_cnt, 255);
    go(29881); chk("wrap_0", rev_cnt, 0);
    go(29883); chk("wrap_pulse", index_n, 0);
    rst = 1'b1; spin_en = 1'b0;
    go(29884); chk("mrst_idx", index_n, 1);
               chk("mrst_rdy", spin_ready, 0);
               chk("mrst_rev", rev_cnt, 0);
    rst = 1'b0; lows = 0;
    while (cyc < 30034) begin
      tick();
      if (index_n !== 1'b1) lows++;
    end
    chk("post_rst_lows", lows, 0);
    chk("post_rst_rdy", spin_ready, 0);
    spin_en = 1'b1; cyc = 0;
    go(1);     chk("restart_n1_idx", index_n, 1);
    go(2);     chk("restart_n2_idx", index_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
